// File: rtl/acc_cpu_pkg.sv
// Shared constants for the accumulator CPU: opcode values, FSM state encoding
// and small opcode-classification helpers.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Opcodes that write ACC and therefore refresh Z.
  function automatic logic op_updates_acc(input logic [3:0] op);
    logic r;
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
      default:                                       r = 1'b0;
    endcase
    return r;
  endfunction

  // LDI keeps C, so only arithmetic and logic ops refresh it.
  function automatic logic op_updates_carry(input logic [3:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: one extra result bit carries ADD carry-out / SUB borrow.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [3:0]        opcode_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] wide_s;

  // Borrow falls out of the top bit of the zero-extended subtraction.
  always_comb begin
    wide_s = {1'b0, acc_i};
    case (opcode_i)
      OP_LDI:  wide_s = {1'b0, imm_i};
      OP_ADD:  wide_s = {1'b0, acc_i} + {1'b0, imm_i};
      OP_SUB:  wide_s = {1'b0, acc_i} - {1'b0, imm_i};
      OP_AND:  wide_s = {1'b0, acc_i & imm_i};
      OP_OR:   wide_s = {1'b0, acc_i | imm_i};
      OP_XOR:  wide_s = {1'b0, acc_i ^ imm_i};
      default: wide_s = {1'b0, acc_i};
    endcase
  end

  assign result_o = wide_s[DATA_W-1:0];
  assign carry_o  = wide_s[DATA_W];
  assign zero_o   = (wide_s[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/acc_cpu.sv
// Accumulator CPU: IDLE/FETCH/EXEC/HALT sequencer, program store and an
// OUT port with a valid/ready handshake that stalls EXEC until accepted.
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [DATA_W-1:0]  ACC,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               halted
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic [INSTR_W-1:0] fetch_word_s;
  logic [3:0]         ir_op_s;
  logic [DATA_W-1:0]  ir_imm_s;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  jmp_tgt_s;
  logic [DATA_W-1:0]  alu_result_s;
  logic               alu_carry_s;
  logic               alu_zero_s;

  assign fetch_word_s = mem_q[pc_q];
  assign ir_op_s      = ir_q[INSTR_W-1:DATA_W];
  assign ir_imm_s     = ir_q[DATA_W-1:0];
  assign pc_inc_s     = pc_q + ADDR_W'(1'b1);
  assign jmp_tgt_s    = ADDR_W'(ir_imm_s);

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_i    (acc_q),
    .imm_i    (ir_imm_s),
    .opcode_i (ir_op_s),
    .result_o (alu_result_s),
    .carry_o  (alu_carry_s),
    .zero_o   (alu_zero_s)
  );

  // Sequencer and datapath next-state; OUT raises valid as it is fetched.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    z_d         = z_q;
    c_d         = c_q;
    ir_d        = ir_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = {ADDR_W{1'b0}};
          acc_d   = {DATA_W{1'b0}};
          z_d     = 1'b0;
          c_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        ir_d    = fetch_word_s;
        state_d = ST_EXEC;
        if (fetch_word_s[INSTR_W-1:DATA_W] == OP_OUT) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (op_updates_acc(ir_op_s)) begin
          acc_d = alu_result_s;
          z_d   = alu_zero_s;
        end else begin
          acc_d = acc_q;
        end
        if (op_updates_carry(ir_op_s)) begin
          c_d = alu_carry_s;
        end else begin
          c_d = c_q;
        end
        case (ir_op_s)
          OP_JMP: pc_d = jmp_tgt_s;
          OP_JZ:  pc_d = z_q ? jmp_tgt_s : pc_inc_s;
          OP_JC:  pc_d = c_q ? jmp_tgt_s : pc_inc_s;
          OP_OUT: begin
            if (out_valid_q && out_ready) begin
              out_valid_d = 1'b0;
              pc_d        = pc_inc_s;
            end else begin
              state_d = ST_EXEC;
              pc_d    = pc_q;
            end
          end
          OP_HLT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          default: pc_d = pc_inc_s;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pc_q        <= {ADDR_W{1'b0}};
      acc_q       <= {DATA_W{1'b0}};
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      ir_q        <= {INSTR_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      ir_q        <= ir_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Program store has no reset so a loaded program outlives rstn.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign ACC       = acc_q;
  assign pc        = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench: directed programs plus random forward-jumping programs,
// each compared against an instruction-level reference interpreter.
module tb_acc_cpu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [11:0] prog_data;
  logic        start;
  logic [7:0]  ACC;
  logic [4:0]  pc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        halted;

  logic        w_we;
  logic [1:0]  w_addr;
  logic [11:0] w_data;
  logic        w_start;
  logic [7:0]  w_acc;
  logic [1:0]  w_pc;
  logic [7:0]  w_out_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic        w_busy;
  logic        w_halted;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int last_cyc;
  int last_stalls;
  logic [11:0] prog [32];
  int exp_q [$];
  int got_q [$];

  always #5 clk = ~clk;

  acc_cpu #(.DATA_W(8), .ADDR_W(5)) u_dut (
    .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .ACC(ACC), .pc(pc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .halted(halted)
  );

  acc_cpu #(.DATA_W(8), .ADDR_W(2)) u_dut_small (
    .clk(clk), .rstn(rstn), .prog_we(w_we), .prog_addr(w_addr),
    .prog_data(w_data), .start(w_start), .ACC(w_acc), .pc(w_pc),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .busy(w_busy), .halted(w_halted)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level interpreter over prog[]; n counts executed instructions incl. HLT.
  task automatic model_run(output int e_acc, output int e_pc, output int n);
    int acc, pcm, op, imm;
    bit z, c, done;
    acc = 0; pcm = 0; z = 0; c = 0; n = 0; done = 0;
    exp_q.delete();
    while (!done && n < 500) begin
      op  = int'(prog[pcm][11:8]);
      imm = int'(prog[pcm][7:0]);
      n++;
      case (op)
        1:  acc = imm;
        2:  begin c = (acc + imm) > 255; acc = (acc + imm) % 256; end
        3:  begin c = acc < imm; acc = (acc - imm + 256) % 256; end
        4:  begin acc = acc & imm; c = 0; end
        5:  begin acc = acc | imm; c = 0; end
        6:  begin acc = acc ^ imm; c = 0; end
        10: exp_q.push_back(acc);
        default: ;
      endcase
      if (op >= 1 && op <= 6) z = (acc == 0);
      if (op == 15) done = 1;
      else if (op == 7 || (op == 8 && z) || (op == 9 && c)) pcm = imm % 32;
      else pcm = (pcm + 1) % 32;
    end
    e_acc = acc;
    e_pc  = pcm;
  endtask

  task automatic load_prog(input int len);
    for (int i = 0; i < len; i++) begin
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  // mode 0: ready always high; 1: random ready and random start noise; 2: hold ready low 4 cycles at OUT.
  task automatic run_prog(input int mode, input string tag);
    int e_acc, e_pc, n, cyc, stalls;
    logic [7:0] prev_data;
    logic [4:0] prev_pc;
    bit held;
    model_run(e_acc, e_pc, n);
    got_q.delete();
    stalls = 0; cyc = 0; held = 0; prev_data = 8'h00; prev_pc = 5'd0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!halted && cyc < 3000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (out_valid && stalls < 4) ? 1'b0 : 1'b1;
      endcase
      start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (out_valid && !out_ready) begin
        stalls++; held = 1; prev_data = out_data; prev_pc = pc;
      end
      tick();
      cyc++;
      if (held) begin
        check_value({tag, "_hold_valid"}, out_valid, 1'b1);
        check_value({tag, "_hold_data"}, out_data, prev_data);
        check_value({tag, "_hold_pc"}, pc, prev_pc);
        held = 0;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    last_cyc = cyc;
    last_stalls = stalls;
    check_value({tag, "_cycles"}, cyc, 2 * n + stalls);
    check_value({tag, "_halted"}, halted, 1'b1);
    check_value({tag, "_busy"}, busy, 1'b0);
    check_value({tag, "_acc"}, ACC, e_acc);
    check_value({tag, "_pc"}, pc, e_pc);
    check_value({tag, "_nout"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_value({tag, "_outval"}, got_q[i], exp_q[i]);
  endtask

  task automatic random_prog();
    int op, imm;
    for (int a = 0; a < 31; a++) begin
      op = $urandom_range(0, 14);
      if (op == 7 || op == 8 || op == 9)
        imm = $urandom_range(a + 1, 31) + 32 * $urandom_range(0, 7);
      else if ($urandom_range(0, 3) == 0)
        imm = $urandom_range(0, 3);
      else
        imm = $urandom_range(0, 255);
      prog[a] = {4'(op), 8'(imm)};
    end
    prog[31] = {4'hF, 8'($urandom_range(0, 255))};
  endtask

  initial begin
    bit seen;
    rstn = 1'b0; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 12'h000;
    start = 1'b0; out_ready = 1'b1;
    w_we = 1'b0; w_addr = 2'd0; w_data = 12'h000; w_start = 1'b0; w_out_ready = 1'b1;
    for (int i = 0; i < 32; i++) prog[i] = 12'hF00;
    tick(); tick();
    check_value("rst_acc", ACC, 8'h00);
    check_value("rst_pc", pc, 5'd0);
    check_value("rst_valid", out_valid, 1'b0);
    check_value("rst_data", out_data, 8'h00);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_halted", halted, 1'b0);
    rstn = 1'b1;
    tick();

    prog[0] = 12'h105; prog[1] = 12'h203; prog[2] = 12'hA00; prog[3] = 12'hF00;
    load_prog(4);
    run_prog(0, "basic");
    check_value("basic_out8", (got_q.size() == 1) ? got_q[0] : -1, 8);
    check_value("basic_pc3", pc, 5'd3);
    check_value("basic_8cyc", last_cyc, 8);

    prog[0] = 12'h1FF; prog[1] = 12'h201; prog[2] = 12'h904; prog[3] = 12'hF00;
    prog[4] = 12'h1AA; prog[5] = 12'h907; prog[6] = 12'hF00; prog[7] = 12'hF00;
    load_prog(8);
    run_prog(0, "carry");
    check_value("carry_accAA", ACC, 8'hAA);
    check_value("carry_pc7", pc, 5'd7);

    prog[0] = 12'h103; prog[1] = 12'h303; prog[2] = 12'h805; prog[3] = 12'hF00;
    prog[4] = 12'hF00; prog[5] = 12'h102; prog[6] = 12'h303; prog[7] = 12'h909;
    prog[8] = 12'hF00; prog[9] = 12'hF00;
    load_prog(10);
    run_prog(0, "borrow");
    check_value("borrow_accFF", ACC, 8'hFF);
    check_value("borrow_pc9", pc, 5'd9);

    prog[0] = 12'h15A; prog[1] = 12'hA00; prog[2] = 12'hF00;
    load_prog(3);
    run_prog(2, "stall");
    check_value("stall_4", last_stalls, 4);
    check_value("stall_cycles", last_cyc, 10);
    check_value("stall_out", (got_q.size() == 1) ? got_q[0] : -1, 8'h5A);

    for (int t = 0; t < 20; t++) begin
      random_prog();
      load_prog(32);
      run_prog(1, "rand");
    end

    // Small-address instance: NOP loop wraps pc 3 -> 0 without halting.
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = 12'h000;
      tick();
    end
    w_we = 1'b0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) check_value("wrap_pc3", w_pc, 2'd3);
      if (k == 8) check_value("wrap_pc0", w_pc, 2'd0);
      if (k == 8 || k == 12) check_value("wrap_busy", w_busy, 1'b1);
    end

    w_out_ready = 1'b0;
    w_we = 1'b1; w_addr = 2'd0; w_data = 12'h177; tick();
    w_addr = 2'd1; w_data = 12'hA00; tick();
    w_we = 1'b0;
    for (int k = 0; k < 40 && !w_out_valid; k++) tick();
    check_value("small_stall_seen", w_out_valid, 1'b1);
    tick(); tick();
    check_value("small_stall_held", w_out_valid, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_value("midrst_acc", w_acc, 8'h00);
    check_value("midrst_pc", w_pc, 2'd0);
    check_value("midrst_valid", w_out_valid, 1'b0);
    check_value("midrst_data", w_out_data, 8'h00);
    check_value("midrst_busy", w_busy, 1'b0);
    check_value("midrst_halted", w_halted, 1'b0);

    w_out_ready = 1'b1;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (w_out_valid && w_out_ready) begin
        seen = 1;
        check_value("survive_out", w_out_data, 8'h77);
      end
      tick();
    end
    check_value("survive_seen", seen, 1'b1);

    // Large instance was reset too; its last random program must still be there.
    run_prog(0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
